// File: rtl/bm_iter_solver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bm_iter_solver
// Brief   : Inversionless iterative Berlekamp-Massey solver over GF(2^M), one
//           iteration per cycle. Define BM_DEG_EN to enable the degree output.
// Revision: 1.0
//------------------------------------------------------------------------------
module bm_iter_solver #(
  parameter int         M    = 4,
  parameter int         T    = 2,
  parameter logic [M:0] POLY = 5'b10011
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(2*T-1)*M-1:0]    syn,
  output logic [(T+1)*M-1:0]      lambda,
  output logic [$clog2(T+1)-1:0]  deg,
  output logic                    busy,
  output logic                    done
);

  localparam int RW = $clog2(T+1);
  localparam int KW = $clog2(T+1) + 2;
  localparam int DW = $clog2(T+1);

  typedef logic [T:0][M-1:0] poly_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam poly_t                c_one_poly = poly_t'(1);
  localparam logic [RW-1:0]        c_r_last   = RW'(T-1);
  localparam logic signed [KW-1:0] c_k_one    = KW'(1);

  state_t                r_state, w_state_nxt;
  logic [2*T-2:0][M-1:0] r_syn;
  poly_t                 r_lam, r_b, w_lam_nxt;
  logic [M-1:0]          r_gamma, w_delta;
  logic signed [KW-1:0]  r_k;
  logic [RW-1:0]         r_r;
  logic                  w_load, w_step;

  // Shift-and-add multiply, reducing by POLY as the multiplicand overflows
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int n = 0; n < M; n++) begin
      if (b[n]) acc = acc ^ sh;
      sh = (sh << 1) ^ (sh[M-1] ? POLY[M-1:0] : '0);
    end
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ITER;
        end
      end
      ITER: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_r == c_r_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Discrepancy: lambda_i pairs with S(2r+1-i), stored at r_syn[2r-i]
  always_comb begin
    w_delta = '0;
    for (int i = 0; i <= T; i++) begin
      for (int j = 0; j < 2*T-1; j++) begin
        if (i + j == 2*int'(r_r)) w_delta = w_delta ^ gf_mul(r_lam[i], r_syn[j]);
      end
    end
  end

  always_comb begin
    w_lam_nxt[0] = gf_mul(r_gamma, r_lam[0]);
    for (int i = 1; i <= T; i++) begin
      w_lam_nxt[i] = gf_mul(r_gamma, r_lam[i]) ^ gf_mul(w_delta, r_b[i-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_syn   <= '0;
      r_lam   <= '0;
      r_b     <= '0;
      r_gamma <= '0;
      r_k     <= '0;
      r_r     <= '0;
    end else if (w_load) begin
      r_syn   <= syn;
      r_lam   <= c_one_poly;
      r_b     <= c_one_poly;
      r_gamma <= M'(1);
      r_k     <= '0;
      r_r     <= '0;
    end else if (w_step) begin
      r_lam <= w_lam_nxt;
      r_r   <= r_r + RW'(1);
      // Shifting the packed polynomial by M bits multiplies by x and drops x^(T+1)
      if ((w_delta != '0) && !r_k[KW-1]) begin
        r_b     <= r_lam << M;
        r_gamma <= w_delta;
        r_k     <= -r_k;
      end else begin
        r_b <= r_b << (2*M);
        r_k <= r_k + c_k_one;
      end
    end
  end

  assign lambda = r_lam;

`ifdef BM_DEG_EN
  logic [DW-1:0] r_deg, w_deg_nxt;

  always_comb begin
    w_deg_nxt = '0;
    for (int i = 1; i <= T; i++) begin
      if (w_lam_nxt[i] != '0) w_deg_nxt = DW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_deg <= '0;
    else if (w_step && (r_r == c_r_last)) r_deg <= w_deg_nxt;
  end

  assign deg = r_deg;
`else
  assign deg = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bm_iter_solver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_bm_iter_solver
// Brief   : Randomised self-checking bench for bm_iter_solver (M=4, T=2).
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_bm_iter_solver;

  localparam int M  = 4;
  localparam int T  = 2;
  localparam int NS = 2*T-1;
  localparam int DW = $clog2(T+1);
  localparam int Q  = (1 << M) - 1;
`ifdef BM_DEG_EN
  localparam bit DEG_EN = 1'b1;
`else
  localparam bit DEG_EN = 1'b0;
`endif

  logic                 clk   = 1'b0;
  logic                 rst   = 1'b0;
  logic                 start = 1'b0;
  logic [NS*M-1:0]      syn   = '0;
  logic [(T+1)*M-1:0]   lambda;
  logic [DW-1:0]        deg;
  logic                 busy;
  logic                 done;

  int n_pass   = 0;
  int n_checks = 0;
  int gexp [0:Q-1];
  int glog [0:Q];

  bm_iter_solver #(.M(M), .T(T), .POLY(5'b10011)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .syn    (syn),
    .lambda (lambda),
    .deg    (deg),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Log/antilog field arithmetic for the reference model
  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % Q];
  endfunction

  task automatic build_tables;
    int x;
    x = 1;
    for (int e = 0; e < Q; e++) begin
      gexp[e] = x;
      glog[x] = e;
      x = x << 1;
      if ((x & (1 << M)) != 0) x = x ^ 'b10011;
    end
  endtask

  task automatic model(input logic [NS*M-1:0] s,
                       output logic [(T+1)*M-1:0] lam_o,
                       output logic [DW-1:0] deg_o);
    int S [1:NS];
    int lam [0:T];
    int nl [0:T];
    int bb [0:T];
    int gamma, k, delta, d;
    for (int j = 1; j <= NS; j++) S[j] = int'(s[(j-1)*M +: M]);
    for (int i = 0; i <= T; i++) begin
      lam[i] = (i == 0) ? 1 : 0;
      bb[i]  = (i == 0) ? 1 : 0;
    end
    gamma = 1;
    k     = 0;
    for (int r = 0; r < T; r++) begin
      delta = 0;
      for (int i = 0; i <= T; i++) begin
        if (2*r+1-i >= 1) delta = delta ^ gmul(lam[i], S[2*r+1-i]);
      end
      nl[0] = gmul(gamma, lam[0]);
      for (int i = 1; i <= T; i++) nl[i] = gmul(gamma, lam[i]) ^ gmul(delta, bb[i-1]);
      if (delta != 0 && k >= 0) begin
        for (int i = T; i >= 1; i--) bb[i] = lam[i-1];
        bb[0] = 0;
        gamma = delta;
        k     = -k;
      end else begin
        for (int i = T; i >= 2; i--) bb[i] = bb[i-2];
        bb[1] = 0;
        bb[0] = 0;
        k     = k + 1;
      end
      for (int i = 0; i <= T; i++) lam[i] = nl[i];
    end
    d = 0;
    for (int i = 0; i <= T; i++) begin
      lam_o[i*M +: M] = lam[i][M-1:0];
      if (lam[i] != 0) d = i;
    end
    deg_o = DEG_EN ? DW'(d) : '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after the edge that accepts start
  task automatic do_start(input logic [NS*M-1:0] s);
    start = 1'b1;
    syn   = s;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (lambda !== '0) $display("FAIL reset_lambda: got %h expected 0", lambda); else n_pass++;
    n_checks++; if (deg !== '0)    $display("FAIL reset_deg: got %0d expected 0", deg);     else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);    else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_known;
    logic [NS*M-1:0]    s;
    logic [DW-1:0]      exp_deg;
    s       = {4'hA, 4'hC, 4'h8};
    exp_deg = DEG_EN ? DW'(1) : '0;
    do_start(s);
    n_checks++; if (busy !== 1'b1) $display("FAIL known_busy: got %b expected 1", busy); else n_pass++;
    for (int n = 1; n <= T; n++) begin
      tick();
      if (n < T) begin
        n_checks++; if (done !== 1'b0) $display("FAIL known_early_done: cycle %0d got %b expected 0", n, done); else n_pass++;
      end
    end
    n_checks++; if (done !== 1'b1)       $display("FAIL known_done: got %b expected 1", done);          else n_pass++;
    n_checks++; if (lambda !== 12'h0C8)  $display("FAIL known_lambda: got %h expected 0c8", lambda);    else n_pass++;
    n_checks++; if (deg !== exp_deg)     $display("FAIL known_deg: got %0d expected %0d", deg, exp_deg); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0)       $display("FAIL known_done_width: got %b expected 0", done);    else n_pass++;
    n_checks++; if (lambda !== 12'h0C8)  $display("FAIL known_hold: got %h expected 0c8", lambda);      else n_pass++;
  endtask

  task automatic test_zero;
    do_start('0);
    for (int n = 1; n <= T; n++) tick();
    n_checks++; if (done !== 1'b1)      $display("FAIL zero_done: got %b expected 1", done);         else n_pass++;
    n_checks++; if (lambda !== 12'h001) $display("FAIL zero_lambda: got %h expected 001", lambda);   else n_pass++;
    n_checks++; if (deg !== '0)         $display("FAIL zero_deg: got %0d expected 0", deg);          else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0)      $display("FAIL zero_done_width: got %b expected 0", done);   else n_pass++;
  endtask

  task automatic test_random;
    logic [NS*M-1:0]    s;
    logic [(T+1)*M-1:0] exp_lam;
    logic [DW-1:0]      exp_deg;
    for (int it = 0; it < 12; it++) begin
      s = NS*M'($urandom);
      model(s, exp_lam, exp_deg);
      do_start(s);
      syn = NS*M'($urandom);
      for (int n = 1; n <= T; n++) tick();
      n_checks++; if (done !== 1'b1)     $display("FAIL rand_done[%0d]: got %b expected 1", it, done); else n_pass++;
      n_checks++; if (lambda !== exp_lam) $display("FAIL rand_lambda[%0d]: syn %h got %h expected %h", it, s, lambda, exp_lam); else n_pass++;
      n_checks++; if (deg !== exp_deg)   $display("FAIL rand_deg[%0d]: syn %h got %0d expected %0d", it, s, deg, exp_deg); else n_pass++;
      tick();
    end
  endtask

  task automatic test_ignore_start;
    logic [NS*M-1:0]    s;
    logic [(T+1)*M-1:0] exp_lam;
    logic [DW-1:0]      exp_deg;
    int                 ndone;
    s = NS*M'($urandom);
    model(s, exp_lam, exp_deg);
    do_start(s);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    n_checks++; if (ndone != 1)         $display("FAIL ignore_ndone: got %0d expected 1", ndone);           else n_pass++;
    n_checks++; if (lambda !== exp_lam) $display("FAIL ignore_lambda: got %h expected %h", lambda, exp_lam); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [NS*M-1:0] s;
    logic            seen;
    s = {4'hA, 4'hC, 4'h8};
    do_start(s);
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy);    else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done);    else n_pass++;
    n_checks++; if (lambda !== '0) $display("FAIL rstmid_lambda: got %h expected 0", lambda); else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done !== 1'b0) seen = 1'b1;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (done !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_done: got %b expected 0", seen); else n_pass++;
    do_start(s);
    for (int n = 1; n <= T; n++) tick();
    n_checks++; if (done !== 1'b1)      $display("FAIL rstmid_resolve_done: got %b expected 1", done);          else n_pass++;
    n_checks++; if (lambda !== 12'h0C8) $display("FAIL rstmid_resolve_lambda: got %h expected 0c8", lambda);    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [NS*M-1:0]    s;
    logic [(T+1)*M-1:0] exp_lam;
    logic [DW-1:0]      exp_deg;
    int                 ndone;
    int                 last;
    s = NS*M'($urandom);
    model(s, exp_lam, exp_deg);
    start = 1'b1;
    syn   = s;
    ndone = 0;
    last  = -1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 10) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        n_checks++; if (lambda !== exp_lam) $display("FAIL b2b_lambda[%0d]: got %h expected %h", c, lambda, exp_lam); else n_pass++;
        n_checks++; if (deg !== exp_deg)    $display("FAIL b2b_deg[%0d]: got %0d expected %0d", c, deg, exp_deg);    else n_pass++;
        if (last >= 0) begin
          n_checks++; if (c - last != T+2) $display("FAIL b2b_spacing: got %0d expected %0d", c - last, T+2); else n_pass++;
        end
        last = c;
      end
    end
    n_checks++; if (ndone != 3) $display("FAIL b2b_ndone: got %0d expected 3", ndone); else n_pass++;
  endtask

  initial begin
    build_tables();
    test_reset();
    test_known();
    test_zero();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bm_iter_solver.md
BM_ITER_SOLVER -- requirements
Module: bm_iter_solver

Interface
REQ-001 SHALL have parameter M, default 4, meaning GF(2^M) symbol width.
REQ-002 SHALL have parameter T, default 2, meaning error-correction capability (T >= 1).
REQ-003 SHALL have parameter POLY, default 5'b10011, meaning primitive polynomial of width M+1 (x^4+x+1).
REQ-004 SHALL have port clk  input  1  meaning the single clock; rising edge active.
REQ-005 SHALL have port rst  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  meaning request to solve; sampled only in IDLE.
REQ-007 SHALL have port syn  input  (2T-1)*M  meaning S1..S(2T-1) packed, with S1 in bits [M-1:0].
REQ-008 SHALL have port lambda  output  (T+1)*M  meaning the unnormalised error locator, with lambda_0 in bits [M-1:0].
REQ-009 SHALL have port deg  output  $clog2(T+1)  meaning the index of the highest nonzero lambda coefficient.
REQ-010 SHALL have port busy  output  1  meaning iteration in progress.
REQ-011 SHALL have port done  output  1  meaning a one-cycle pulse that marks lambda and deg valid.

Function
REQ-012 SHALL implement the FSM states IDLE, ITER and DONE.
REQ-013 SHALL, on an edge in IDLE with start=1, latch syn, set lambda=1, B=1, gamma=1, k=0 and r=0, and go to ITER.
REQ-014 SHALL, in ITER, perform one iteration per cycle for r=0..T-1, and go to DONE on the edge that completes r=T-1.
REQ-015 SHALL compute delta = XOR-sum over i=0..T of lambda_i*S(2r+1-i), treating terms with index < 1 as 0.
REQ-016 SHALL update lambda <- gamma*lambda XOR delta*x*B, using all GF products reduced modulo POLY.
REQ-017 SHALL, if delta!=0 and k>=0, set B <- x*lambda(old), gamma <- delta and k <- -k.
REQ-018 SHALL otherwise set B <- x^2*B and k <- k+1.
REQ-019 SHALL truncate the products x*B, x^2*B and x*lambda to T+1 coefficients.
REQ-020 SHALL hold k as a signed register of width $clog2(T+1)+2.
REQ-021 SHALL go from DONE to IDLE on the next edge.
REQ-022 SHALL assert done only in DONE.
REQ-023 SHALL assert busy only in ITER.
REQ-024 SHALL assert done T+1 cycles after the start edge.
REQ-025 SHALL hold lambda and deg stable from DONE until the next accepted start.
REQ-026 SHALL ignore start while in ITER or DONE; no queuing.
REQ-027 SHALL ignore changes on syn after the start edge.
REQ-028 SHALL treat back-to-back solves as: start held high through DONE is accepted on the first IDLE edge.
REQ-029 SHALL, for all-zero syndromes, produce lambda=1 and deg=0.

Reset
REQ-030 SHALL, when rst=0, immediately force state=IDLE, lambda=0, B=0, gamma=0, k=0, r=0, deg=0, busy=0 and done=0, regardless of clock.
REQ-031 SHALL abort any solve on reset mid-ITER, with no done pulse.
REQ-032 SHALL accept start on the first edge after reset release.

Configuration
REQ-033 SHALL, with macro BM_DEG_EN defined, register deg on the ITER->DONE edge as the highest nonzero index of the final lambda.
REQ-034 SHALL, without BM_DEG_EN, retain the deg port, tie it to 0 and synthesise no degree logic.

Verification
REQ-035 SHALL pass, with M=4 and T=2: syn S1=8, S2=C, S3=A (single error at alpha^3) -> done at the 3rd cycle after start, lambda={0,C,8} (lambda_2..lambda_0), deg=1 with BM_DEG_EN.
REQ-036 SHALL pass: all-zero syn -> lambda={0,0,1}, deg=0, done pulse of width 1.
REQ-037 SHALL pass: start pulsed in cycles 1 and 2 after an accepted start -> ignored, exactly one done.
REQ-038 SHALL pass: rst=0 in the cycle after start -> busy=0, done never asserts, outputs 0; a new start then solves correctly.
REQ-039 SHALL pass: start held high for 10 cycles with fixed syn -> done every 4 cycles, identical lambda each time.
REQ-040 SHALL pass: build without BM_DEG_EN -> deg=0 in all scenarios, lambda unchanged.
